// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU result stream, LSU/MDU result handshakes,
// flush, and the single registered writeback port.
// Handshake rule: a LSU or MDU transfer happens in a cycle where both
// valid and ready are high; a source holds valid and payload stable until
// it sees ready. The ALU stream has no ready and is always accepted.
interface wb_arbiter_if #(
   parameter int SCOREBOARD_SIZE_WIDTH = 4
);
   logic                             flush_i;
   logic                             alu_exe_valid_i;
   logic [SCOREBOARD_SIZE_WIDTH-1:0] alu_sid_i;
   logic [4:0]                       alu_exe_rd_i;
   logic [63:0]                      alu_exe_rd_value_i;
   logic                             alu_afull_o;
   logic                             lsu_valid_i;
   logic                             lsu_ready_o;
   logic [SCOREBOARD_SIZE_WIDTH-1:0] lsu_sid_i;
   logic [4:0]                       lsu_rd_i;
   logic [63:0]                      lsu_value_i;
   logic                             mdu_valid_i;
   logic                             mdu_ready_o;
   logic [SCOREBOARD_SIZE_WIDTH-1:0] mdu_sid_i;
   logic [4:0]                       mdu_rd_i;
   logic [63:0]                      mdu_value_i;
   logic                             wb_valid_o;
   logic                             wb_we_o;
   logic [SCOREBOARD_SIZE_WIDTH-1:0] wb_sid_o;
   logic [4:0]                       wb_rd_o;
   logic [63:0]                      wb_value_o;
   logic                             alu_ovf_o;

   // Execute-unit / pipeline side.
   modport master (
      output flush_i, alu_exe_valid_i, alu_sid_i, alu_exe_rd_i, alu_exe_rd_value_i,
      output lsu_valid_i, lsu_sid_i, lsu_rd_i, lsu_value_i,
      output mdu_valid_i, mdu_sid_i, mdu_rd_i, mdu_value_i,
      input  alu_afull_o, lsu_ready_o, mdu_ready_o,
      input  wb_valid_o, wb_we_o, wb_sid_o, wb_rd_o, wb_value_o, alu_ovf_o
   );

   // Arbiter side.
   modport slave (
      input  flush_i, alu_exe_valid_i, alu_sid_i, alu_exe_rd_i, alu_exe_rd_value_i,
      input  lsu_valid_i, lsu_sid_i, lsu_rd_i, lsu_value_i,
      input  mdu_valid_i, mdu_sid_i, mdu_rd_i, mdu_value_i,
      output alu_afull_o, lsu_ready_o, mdu_ready_o,
      output wb_valid_o, wb_we_o, wb_sid_o, wb_rd_o, wb_value_o, alu_ovf_o
   );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers the ALU result stream in a small FIFO and
// round-robins (ALU->LSU->MDU) between it and the LSU/MDU handshakes onto a
// single registered writeback port. A nearly full FIFO forces the ALU to win.
// Optional feature macro WB_ALU_BYPASS_EN: an ALU result arriving to an empty
// FIFO may be granted in the same cycle and skip the FIFO.
// rr_state exposes the round-robin pointer (0 ALU, 1 LSU, 2 MDU) for debug.
module wb_arbiter #(
   parameter int ALU_FIFO_DEPTH        = 4,
   parameter int SCOREBOARD_SIZE_WIDTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   wb_arbiter_if.slave bus,
   output logic [1:0] rr_state
);
   localparam int SW = SCOREBOARD_SIZE_WIDTH;
   localparam int AW = $clog2(ALU_FIFO_DEPTH);
   localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(ALU_FIFO_DEPTH);
   localparam logic [AW:0]   CNT_HI    = (AW+1)'(ALU_FIFO_DEPTH - 1);
   localparam logic [AW:0]   CNT_AF    = (AW+1)'(ALU_FIFO_DEPTH - 2);
   localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);

   typedef struct packed {
      logic [SW-1:0] sid;
      logic [4:0]    rd;
      logic [63:0]   value;
   } entry_t;

   typedef enum logic [1:0] {SRC_ALU = 2'd0, SRC_LSU = 2'd1, SRC_MDU = 2'd2} src_e;

   function automatic src_e next_src(input src_e s);
      case (s)
         SRC_ALU: next_src = SRC_LSU;
         SRC_LSU: next_src = SRC_MDU;
         default: next_src = SRC_ALU;
      endcase
   endfunction

   entry_t        mem [ALU_FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   src_e          rr_q, rr_d, c1, c2;
   logic          alu_live_in, alu_req, override, gnt_any;
   logic [2:0]    req;
   src_e          gnt_src;
   logic          pop, push, bypass_take, ovf_set;
   entry_t        alu_in, gnt_payload, wb_q;
   logic          wb_valid_q, ovf_q;

   assign alu_in = '{sid: bus.alu_sid_i, rd: bus.alu_exe_rd_i, value: bus.alu_exe_rd_value_i};

`ifdef WB_ALU_BYPASS_EN
   assign alu_live_in = (count == '0) && bus.alu_exe_valid_i;
`else
   assign alu_live_in = 1'b0;
`endif

   assign alu_req  = (count != '0) || alu_live_in;
   assign req      = {bus.mdu_valid_i, bus.lsu_valid_i, alu_req};
   assign override = (count >= CNT_HI);
   assign c1       = next_src(rr_q);
   assign c2       = next_src(c1);

   // Round-robin pointer register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rr_q <= SRC_ALU;
      else     rr_q <= rr_d;
   end

   // Grant selection and next pointer: override first, then rotate from rr
   always_comb begin
      gnt_any = 1'b0;
      gnt_src = SRC_ALU;
      rr_d    = rr_q;
      if (!rst && !bus.flush_i) begin
         if (override) begin
            gnt_any = 1'b1;
            gnt_src = SRC_ALU;
         end else if (req[rr_q]) begin
            gnt_any = 1'b1;
            gnt_src = rr_q;
         end else if (req[c1]) begin
            gnt_any = 1'b1;
            gnt_src = c1;
         end else if (req[c2]) begin
            gnt_any = 1'b1;
            gnt_src = c2;
         end
      end
      if (gnt_any) rr_d = next_src(gnt_src);
   end

   // Grant decode to the LSU/MDU readies
   always_comb begin
      bus.lsu_ready_o = gnt_any && (gnt_src == SRC_LSU);
      bus.mdu_ready_o = gnt_any && (gnt_src == SRC_MDU);
      rr_state        = rr_q;
   end

   // An ALU grant with an empty FIFO can only be the bypass path.
   assign bypass_take = gnt_any && (gnt_src == SRC_ALU) && (count == '0);
   assign pop         = gnt_any && (gnt_src == SRC_ALU) && (count != '0);
   assign push        = bus.alu_exe_valid_i && !bus.flush_i && !bypass_take
                        && ((count != CNT_DEPTH) || pop);
   assign ovf_set     = bus.alu_exe_valid_i && !bus.flush_i && !bypass_take
                        && (count == CNT_DEPTH) && !pop;

   // FIFO pointers and occupancy; flush empties the buffer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (bus.flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // FIFO storage, written only on an accepted push
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= alu_in;
   end

   // Payload of the granted source
   always_comb begin
      gnt_payload = '0;
      case (gnt_src)
         SRC_LSU: gnt_payload = '{sid: bus.lsu_sid_i, rd: bus.lsu_rd_i, value: bus.lsu_value_i};
         SRC_MDU: gnt_payload = '{sid: bus.mdu_sid_i, rd: bus.mdu_rd_i, value: bus.mdu_value_i};
         default: gnt_payload = (count == '0) ? alu_in : mem[rd_ptr];
      endcase
   end

   // Writeback register: one valid pulse per grant, payload held otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_valid_q <= 1'b0;
         wb_q       <= '0;
      end else begin
         wb_valid_q <= gnt_any;
         if (gnt_any) wb_q <= gnt_payload;
      end
   end

   // Sticky overflow flag, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          ovf_q <= 1'b0;
      else if (ovf_set) ovf_q <= 1'b1;
   end

   assign bus.wb_valid_o  = wb_valid_q;
   assign bus.wb_we_o     = wb_valid_q && (wb_q.rd != 5'd0);
   assign bus.wb_sid_o    = wb_q.sid;
   assign bus.wb_rd_o     = wb_q.rd;
   assign bus.wb_value_o  = wb_q.value;
   assign bus.alu_ovf_o   = ovf_q;
   assign bus.alu_afull_o = (count >= CNT_AF);
endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios plus random traffic, all
// checked cycle by cycle against a queue-based reference model.
module tb_wb_arbiter;
   localparam int DEPTH = 4;
   localparam int SW    = 4;
`ifdef WB_ALU_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   typedef struct packed {
      logic [SW-1:0] sid;
      logic [4:0]    rd;
      logic [63:0]   value;
   } res_t;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] rr_state;
   always #5 clk = ~clk;

   wb_arbiter_if #(.SCOREBOARD_SIZE_WIDTH(SW)) bus ();

   wb_arbiter #(.ALU_FIFO_DEPTH(DEPTH), .SCOREBOARD_SIZE_WIDTH(SW)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .rr_state (rr_state)
   );

   // ---------------- reference model state ----------------
   res_t exp_q[$];       // ALU results waiting, in arrival order
   int   m_rr;           // 0 ALU, 1 LSU, 2 MDU
   bit   m_ovf;
   bit   e_valid;
   res_t e_wb;
   int   last_g      = -1;
   bit   model_afull = 1'b0;
   bit   s_wb_valid  = 1'b0;
   int   n_checks    = 0;
   int   n_fail      = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_rr        = 0;
      m_ovf       = 1'b0;
      e_valid     = 1'b0;
      e_wb        = '0;
      last_g      = -1;
      model_afull = 1'b0;
   endtask

   // Winner for this cycle: -1 none, else source index.
   function automatic int model_grant();
      bit req [3];
      req[0] = (exp_q.size() > 0) || (BYPASS && bus.alu_exe_valid_i && exp_q.size() == 0);
      req[1] = bus.lsu_valid_i;
      req[2] = bus.mdu_valid_i;
      if (bus.flush_i) return -1;
      if (exp_q.size() >= DEPTH - 1) return 0;
      for (int k = 0; k < 3; k++)
         if (req[(m_rr + k) % 3]) return (m_rr + k) % 3;
      return -1;
   endfunction

   // One clock: check at negedge, advance the model, return at posedge+1.
   task automatic cycle();
      int   g;
      bit   byp;
      res_t in_alu, in_lsu, in_mdu;
      @(negedge clk);
      g = model_grant();
      check("lsu_ready", bus.lsu_ready_o, g == 1);
      check("mdu_ready", bus.mdu_ready_o, g == 2);
      check("alu_afull", bus.alu_afull_o, exp_q.size() >= DEPTH - 2);
      check("alu_ovf", bus.alu_ovf_o, m_ovf);
      check("rr", rr_state, m_rr[1:0]);
      check("wb_valid", bus.wb_valid_o, e_valid);
      check("wb_we", bus.wb_we_o, e_valid && (e_wb.rd != 5'd0));
      if (e_valid) begin
         check("wb_sid", bus.wb_sid_o, e_wb.sid);
         check("wb_rd", bus.wb_rd_o, e_wb.rd);
         check("wb_value", bus.wb_value_o, e_wb.value);
      end
      s_wb_valid  = bus.wb_valid_o;
      model_afull = (exp_q.size() >= DEPTH - 2);
      in_alu = {bus.alu_sid_i, bus.alu_exe_rd_i, bus.alu_exe_rd_value_i};
      in_lsu = {bus.lsu_sid_i, bus.lsu_rd_i, bus.lsu_value_i};
      in_mdu = {bus.mdu_sid_i, bus.mdu_rd_i, bus.mdu_value_i};
      if (bus.flush_i) begin
         exp_q.delete();
         e_valid = 1'b0;
      end else begin
         byp = 1'b0;
         if (g == 0) begin
            if (exp_q.size() > 0) e_wb = exp_q.pop_front();
            else begin
               e_wb = in_alu;
               byp  = 1'b1;
            end
         end else if (g == 1) e_wb = in_lsu;
         else if (g == 2) e_wb = in_mdu;
         e_valid = (g >= 0);
         if (g >= 0) m_rr = (g + 1) % 3;
         if (bus.alu_exe_valid_i && !byp) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(in_alu);
            else m_ovf = 1'b1;
         end
      end
      last_g = g;
      @(posedge clk);
      #1;
   endtask

   // ---------------- driver ----------------
   // LSU/MDU keep valid and payload until accepted.
   task automatic drive(input bit av, input bit lv, input bit mv, input bit fl);
      bus.flush_i            = fl;
      bus.alu_exe_valid_i    = av;
      bus.alu_sid_i          = SW'($urandom());
      bus.alu_exe_rd_i       = 5'($urandom());
      bus.alu_exe_rd_value_i = {$urandom(), $urandom()};
      if (!(bus.lsu_valid_i && last_g != 1)) begin
         bus.lsu_valid_i = lv;
         bus.lsu_sid_i   = SW'($urandom());
         bus.lsu_rd_i    = 5'($urandom());
         bus.lsu_value_i = {$urandom(), $urandom()};
      end
      if (!(bus.mdu_valid_i && last_g != 2)) begin
         bus.mdu_valid_i = mv;
         bus.mdu_sid_i   = SW'($urandom());
         bus.mdu_rd_i    = 5'($urandom());
         bus.mdu_value_i = {$urandom(), $urandom()};
      end
   endtask

   task automatic clear_inputs();
      bus.flush_i = 1'b0; bus.alu_exe_valid_i = 1'b0; bus.lsu_valid_i = 1'b0; bus.mdu_valid_i = 1'b0;
      bus.alu_sid_i = '0; bus.alu_exe_rd_i = '0; bus.alu_exe_rd_value_i = '0;
      bus.lsu_sid_i = '0; bus.lsu_rd_i = '0; bus.lsu_value_i = '0;
      bus.mdu_sid_i = '0; bus.mdu_rd_i = '0; bus.mdu_value_i = '0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_wb_valid"}, bus.wb_valid_o, 0);
      check({tag, "_wb_we"}, bus.wb_we_o, 0);
      check({tag, "_wb_sid"}, bus.wb_sid_o, 0);
      check({tag, "_wb_rd"}, bus.wb_rd_o, 0);
      check({tag, "_wb_value"}, bus.wb_value_o, 0);
      check({tag, "_alu_ovf"}, bus.alu_ovf_o, 0);
      check({tag, "_alu_afull"}, bus.alu_afull_o, 0);
      check({tag, "_lsu_ready"}, bus.lsu_ready_o, 0);
      check({tag, "_mdu_ready"}, bus.mdu_ready_o, 0);
      check({tag, "_rr"}, rr_state, 0);
   endtask

   // ---------------- scenarios ----------------
   initial begin
      int lat;
      clear_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Round-robin with all three sources competing
      drive(1, 0, 0, 0); cycle();
      for (int i = 0; i < 12; i++) begin
         drive(i % 3 == 0, 1, 1, 0); cycle();
      end
      drive(0, 0, 0, 0); repeat (6) cycle();

      // FIFO pressure: ALU override with LSU/MDU waiting
      for (int i = 0; i < 12; i++) begin
         drive(1, 1, 1, 0); cycle();
      end
      drive(0, 0, 0, 0); repeat (8) cycle();

      // MDU result to x0: released but not written
      drive(0, 0, 1, 0);
      bus.mdu_rd_i  = 5'd0;
      bus.mdu_sid_i = SW'(2);
      cycle();
      drive(0, 0, 0, 0); cycle();
      repeat (2) cycle();

      // Flush with queued ALU entries and a waiting LSU
      drive(1, 1, 1, 0); cycle();
      drive(1, 1, 1, 0); cycle();
      drive(1, 1, 0, 1); cycle();
      drive(0, 1, 0, 0); cycle();
      drive(0, 0, 0, 0); repeat (6) cycle();

      // Reset in the middle of traffic
      for (int i = 0; i < 6; i++) begin
         drive(1, 1, 1, 0); cycle();
      end
      rst = 1'b1;
      #1;
      check_zero("midrst");
      clear_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      drive(0, 1, 0, 0);
      bus.lsu_sid_i   = SW'(5);
      bus.lsu_rd_i    = 5'd3;
      bus.lsu_value_i = 64'h1234;
      cycle();
      drive(0, 0, 0, 0); cycle();
      check("post_rst_value", bus.wb_value_o, 64'h1234);
      repeat (2) cycle();

      // ALU latency from an empty FIFO
      drive(1, 0, 0, 0);
      bus.alu_exe_rd_value_i = 64'hDEAD;
      cycle();
      drive(0, 0, 0, 0);
      lat = 0;
      for (int k = 1; k <= 4; k++) begin
         cycle();
         if (s_wb_valid && lat == 0) lat = k;
      end
      check("alu_latency", lat, BYPASS ? 1 : 2);

      // Random traffic, issue honours alu_afull_o
      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(99) < 60) && !model_afull, $urandom_range(99) < 40,
               $urandom_range(99) < 40, $urandom_range(99) < 3);
         cycle();
      end

      // Random traffic, ALU issues regardless of alu_afull_o
      for (int i = 0; i < 200; i++) begin
         drive($urandom_range(99) < 90, $urandom_range(99) < 70,
               $urandom_range(99) < 70, $urandom_range(99) < 1);
         cycle();
      end
      drive(0, 0, 0, 0); repeat (10) cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
